sat_accum_stream: RTL and testbench

// - Streaming saturating accumulator; the sequential, parametrised successor of the 4-bit combinational saturating adder.
// - Sums a packet of W-bit samples (valid/ready, last-marked) into an ACC_W-bit register.
// - Saturates at every step, signed or unsigned per SIGNED.
// - Emits one result per packet with a sticky saturation flag and a sample count.
// - Sits between a sample source (e.g. ADC/filter stage) and a consumer taking per-packet sums.
//

---
 rtl/sat_accum_pkg.sv | 40 ++++
 rtl/sat_add_core.sv | 46 ++++
 rtl/sat_accum_stream.sv | 124 ++++++++++++
 tb/tb_sat_accum_stream.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_accum_pkg.sv
// Shared definitions for saturating arithmetic blocks: clamp-value helpers
// and a few ready-made clamp constants for common accumulator widths.
package sat_accum_pkg;

    // Widest accumulator the clamp helpers can describe.
    localparam int SAT_FN_W = 64;

    // Largest representable value of an acc_w-bit accumulator:
    // 0111..1 when signed, 1111..1 when unsigned.
    function automatic logic [SAT_FN_W-1:0] sat_max(input int acc_w, input bit is_signed);
        logic [SAT_FN_W-1:0] r;
        r = '0;
        for (int i = 0; i < SAT_FN_W; i++) begin
            if (i < acc_w) begin
                r[i] = 1'b1;
            end
        end
        if (is_signed && acc_w > 0) begin
            r[acc_w-1] = 1'b0;
        end
        return r;
    endfunction

    // Smallest representable value: 1000..0 when signed, zero when unsigned.
    function automatic logic [SAT_FN_W-1:0] sat_min(input int acc_w, input bit is_signed);
        logic [SAT_FN_W-1:0] r;
        r = '0;
        if (is_signed && acc_w > 0) begin
            r[acc_w-1] = 1'b1;
        end
        return r;
    endfunction

    // Clamp values for the default 16-bit accumulator.
    localparam logic [SAT_FN_W-1:0] SAT_MAX_S16 = sat_max(16, 1'b1);
    localparam logic [SAT_FN_W-1:0] SAT_MIN_S16 = sat_min(16, 1'b1);
    localparam logic [SAT_FN_W-1:0] SAT_MAX_U16 = sat_max(16, 1'b0);
    localparam logic [SAT_FN_W-1:0] SAT_MIN_U16 = sat_min(16, 1'b0);

endpackage

// File: rtl/sat_add_core.sv
// Combinational saturating adder: sum = clamp(a + b) with an overflow flag.
// Both operands are already ACC_W wide; the add is done one bit wider.
module sat_add_core
    import sat_accum_pkg::*;
#(
    parameter int ACC_W  = 16,
    parameter bit SIGNED = 1'b1
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);

    localparam logic [SAT_FN_W-1:0] MAX_FULL = sat_max(ACC_W, SIGNED);
    localparam logic [SAT_FN_W-1:0] MIN_FULL = sat_min(ACC_W, SIGNED);
    localparam logic [ACC_W-1:0]    MAX_V    = MAX_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0]    MIN_V    = MIN_FULL[ACC_W-1:0];

    logic [ACC_W:0] a_x;
    logic [ACC_W:0] b_x;
    logic [ACC_W:0] raw;
    logic           ovf;

    // Widen, add, detect overflow and clamp toward the operands' direction.
    always_comb begin
        if (SIGNED) begin
            a_x = {a[ACC_W-1], a};
            b_x = {b[ACC_W-1], b};
        end else begin
            a_x = {1'b0, a};
            b_x = {1'b0, b};
        end
        raw = a_x + b_x;
        if (SIGNED) begin
            // Same-sign operands whose ACC_W-bit result flips sign overflowed.
            ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
            sum = ovf ? (a[ACC_W-1] ? MIN_V : MAX_V) : raw[ACC_W-1:0];
        end else begin
            ovf = raw[ACC_W];
            sum = ovf ? MAX_V : raw[ACC_W-1:0];
        end
        sat = ovf;
    end

endmodule

// File: rtl/sat_accum_stream.sv
// Streaming saturating accumulator: sums each last-terminated packet of
// samples with per-step clamping and presents one result per packet,
// together with a sticky saturation flag and a saturating sample count.
module sat_accum_stream
    import sat_accum_pkg::*;
#(
    parameter int W      = 8,
    parameter int ACC_W  = 16,
    parameter bit SIGNED = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [W-1:0]     up_data,
    input  logic             up_last,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [ACC_W-1:0] down_data,
    output logic             down_sat,
    output logic [CNT_W-1:0] down_count
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [ACC_W-1:0] data_q, data_d;
    logic             dsat_q, dsat_d;
    logic [CNT_W-1:0] dcount_q, dcount_d;

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] sum;
    logic             sat_now;
    logic             up_fire;
    logic             down_fire;
    logic [CNT_W-1:0] cnt_inc;

    // Bring the sample to accumulator width, sign- or zero-filled.
    generate
        if (ACC_W > W) begin : g_ext
            if (SIGNED) begin : g_sext
                assign ext = {{(ACC_W-W){up_data[W-1]}}, up_data};
            end else begin : g_zext
                assign ext = {{(ACC_W-W){1'b0}}, up_data};
            end
        end else begin : g_noext
            assign ext = up_data;
        end
    endgenerate

    sat_add_core #(
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_add (
        .a   (acc_q),
        .b   (ext),
        .sum (sum),
        .sat (sat_now)
    );

    // The result register doubles as the FSM: empty accepts, full holds.
    assign up_ready   = ~valid_q | down_ready;
    assign up_fire    = up_valid & up_ready;
    assign down_fire  = valid_q & down_ready;
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    assign down_valid = valid_q;
    assign down_data  = data_q;
    assign down_sat   = dsat_q;
    assign down_count = dcount_q;

    // Next-state: accumulate non-last beats, publish and clear on the last.
    always_comb begin
        acc_d    = acc_q;
        sat_d    = sat_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        data_d   = data_q;
        dsat_d   = dsat_q;
        dcount_d = dcount_q;
        if (down_fire) begin
            valid_d = 1'b0;
        end
        if (up_fire) begin
            if (up_last) begin
                data_d   = sum;
                dsat_d   = sat_q | sat_now;
                dcount_d = cnt_inc;
                valid_d  = 1'b1;
                acc_d    = '0;
                sat_d    = 1'b0;
                cnt_d    = '0;
            end else begin
                acc_d = sum;
                sat_d = sat_q | sat_now;
                cnt_d = cnt_inc;
            end
        end
    end

    // State registers; reset discards any partial packet and pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            sat_q    <= 1'b0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            dsat_q   <= 1'b0;
            dcount_q <= '0;
        end else begin
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            dsat_q   <= dsat_d;
            dcount_q <= dcount_d;
        end
    end

endmodule

// File: tb/tb_sat_accum_stream.sv
// Bench for sat_accum_stream: a signed (W=4, ACC_W=4, CNT_W=16) and an
// unsigned (W=4, ACC_W=4, CNT_W=3) instance share one stimulus stream; an
// integer reference model feeds per-instance scoreboards drained by a monitor.
module tb_sat_accum_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       up_valid;
    logic       up_last;
    logic [3:0] up_data;
    logic       down_ready;

    logic        up_ready_s, dv_s, dsat_s;
    logic [3:0]  dd_s;
    logic [15:0] dcnt_s;
    logic        up_ready_u, dv_u, dsat_u;
    logic [3:0]  dd_u;
    logic [2:0]  dcnt_u;

    sat_accum_stream #(.W(4), .ACC_W(4), .SIGNED(1'b1), .CNT_W(16)) dut_s (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready_s), .up_data(up_data), .up_last(up_last),
        .down_valid(dv_s), .down_ready(down_ready),
        .down_data(dd_s), .down_sat(dsat_s), .down_count(dcnt_s)
    );

    sat_accum_stream #(.W(4), .ACC_W(4), .SIGNED(1'b0), .CNT_W(3)) dut_u (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready_u), .up_data(up_data), .up_last(up_last),
        .down_valid(dv_u), .down_ready(down_ready),
        .down_data(dd_u), .down_sat(dsat_u), .down_count(dcnt_u)
    );

    typedef struct {
        int data;
        bit sat;
        int cnt;
    } res_t;

    res_t q_s[$];
    res_t q_u[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: packet sums as plain integers.
    int m_acc_s, m_acc_u, m_cnt_s, m_cnt_u;
    bit m_sat_s, m_sat_u;
    bit last_fire;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_acc_s = 0; m_acc_u = 0; m_cnt_s = 0; m_cnt_u = 0;
        m_sat_s = 0; m_sat_u = 0;
        q_s.delete();
        q_u.delete();
    endtask

    // One accepted beat: add with clamp to [-8,7] (signed) or [0,15] (unsigned).
    task automatic model_beat();
        int vs, vu;
        bit ss, su;
        res_t r;
        vs = m_acc_s + int'($signed(up_data));
        ss = (vs > 7) || (vs < -8);
        if (vs > 7)  vs = 7;
        if (vs < -8) vs = -8;
        vu = m_acc_u + int'(up_data);
        su = (vu > 15);
        if (su) vu = 15;
        m_cnt_s = (m_cnt_s == 65535) ? m_cnt_s : m_cnt_s + 1;
        m_cnt_u = (m_cnt_u == 7) ? m_cnt_u : m_cnt_u + 1;
        if (up_last) begin
            r.data = vs & 15; r.sat = m_sat_s | ss; r.cnt = m_cnt_s;
            q_s.push_back(r);
            r.data = vu;      r.sat = m_sat_u | su; r.cnt = m_cnt_u;
            q_u.push_back(r);
            m_acc_s = 0; m_acc_u = 0; m_cnt_s = 0; m_cnt_u = 0;
            m_sat_s = 0; m_sat_u = 0;
        end else begin
            m_acc_s = vs; m_sat_s = m_sat_s | ss;
            m_acc_u = vu; m_sat_u = m_sat_u | su;
        end
    endtask

    // Advance one clock: decide acceptance mid-cycle, then pass the edge.
    task automatic step();
        @(negedge clk);
        last_fire = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            chk("up_ready_s", 32'(up_ready_s), 32'(!dv_s || down_ready));
            chk("up_ready_u", 32'(up_ready_u), 32'(!dv_u || down_ready));
            if (up_valid && up_ready_s) begin
                last_fire = 1'b1;
                model_beat();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic l);
        bit fired;
        fired = 1'b0;
        up_valid = 1'b1;
        up_data  = d;
        up_last  = l;
        for (int k = 0; k < 64; k++) begin
            step();
            if (last_fire) begin
                fired = 1'b1;
                break;
            end
        end
        if (!fired) fail_now("send_timeout");
        if (fired && l) chk("latency", 32'(dv_s), 32'd1);
        up_valid = 1'b0;
        up_last  = 1'b0;
    endtask

    // Monitor: every down beat pops one expected result per instance.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && down_ready === 1'b1) begin
                if (dv_s) begin
                    if (q_s.size() == 0) begin
                        fail_now("s_unexpected_result");
                    end else begin
                        r = q_s.pop_front();
                        chk("s_data",  32'(dd_s),   r.data);
                        chk("s_sat",   32'(dsat_s), 32'(r.sat));
                        chk("s_count", 32'(dcnt_s), r.cnt);
                    end
                end
                if (dv_u) begin
                    if (q_u.size() == 0) begin
                        fail_now("u_unexpected_result");
                    end else begin
                        r = q_u.pop_front();
                        chk("u_data",  32'(dd_u),   r.data);
                        chk("u_sat",   32'(dsat_u), 32'(r.sat));
                        chk("u_count", 32'(dcnt_u), r.cnt);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; up_valid = 1'b0; up_last = 1'b0; up_data = '0; down_ready = 1'b1;
        repeat (2) step();
        chk("rst_valid_s", 32'(dv_s), 32'd0);
        chk("rst_data_s",  32'(dd_s), 32'd0);
        chk("rst_sat_s",   32'(dsat_s), 32'd0);
        chk("rst_count_s", 32'(dcnt_s), 32'd0);
        chk("rst_valid_u", 32'(dv_u), 32'd0);
        rst = 1'b0;
        step();

        // {3,2,1}: plain sum
        send(4'd3, 1'b0); send(4'd2, 1'b0); send(4'd1, 1'b1);
        chk("p321_data", 32'(dd_s), 32'h6);
        chk("p321_sat",  32'(dsat_s), 32'd0);
        chk("p321_cnt",  32'(dcnt_s), 32'd3);
        // {7,1}: positive clamp
        send(4'd7, 1'b0); send(4'd1, 1'b1);
        chk("p71_data", 32'(dd_s), 32'h7);
        chk("p71_sat",  32'(dsat_s), 32'd1);
        // {-8,-1}: negative clamp
        send(4'h8, 1'b0); send(4'hF, 1'b1);
        chk("pm8m1_data", 32'(dd_s), 32'h8);
        chk("pm8m1_sat",  32'(dsat_s), 32'd1);
        // {7,1,-1}: clamping is per step, so order matters
        send(4'd7, 1'b0); send(4'd1, 1'b0); send(4'hF, 1'b1);
        chk("order_data", 32'(dd_s), 32'h6);
        chk("order_sat",  32'(dsat_s), 32'd1);
        // unsigned {15,1} and {8,7}
        send(4'hF, 1'b0); send(4'd1, 1'b1);
        chk("u151_data", 32'(dd_u), 32'hF);
        chk("u151_sat",  32'(dsat_u), 32'd1);
        send(4'd8, 1'b0); send(4'd7, 1'b1);
        chk("u87_data", 32'(dd_u), 32'hF);
        chk("u87_sat",  32'(dsat_u), 32'd0);
        // ten-beat packet: unsigned 3-bit counter pins at 7
        for (int i = 0; i < 10; i++) send(4'd1, (i == 9) ? 1'b1 : 1'b0);
        chk("long_cnt_s", 32'(dcnt_s), 32'd10);
        chk("long_cnt_u", 32'(dcnt_u), 32'd7);
        chk("long_data_s", 32'(dd_s), 32'h7);
        step();

        // Backpressure: result held, upstream stalled for five cycles
        down_ready = 1'b0;
        send(4'd2, 1'b0); send(4'd3, 1'b1);
        up_valid = 1'b1; up_data = 4'd4; up_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_up_ready", 32'(up_ready_s), 32'd0);
            chk("bp_valid",    32'(dv_s), 32'd1);
            chk("bp_data",     32'(dd_s), 32'd5);
            chk("bp_count",    32'(dcnt_s), 32'd2);
        end
        down_ready = 1'b1;
        send(4'd5, 1'b1);
        chk("bb_valid", 32'(dv_s), 32'd1);
        chk("bb_data",  32'(dd_s), 32'd5);
        chk("bb_count", 32'(dcnt_s), 32'd1);
        step();

        // Reset mid-packet discards the partial sum
        send(4'd3, 1'b0); send(4'd3, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(dv_s), 32'd0);
        chk("mid_rst_data",  32'(dd_s), 32'd0);
        send(4'd1, 1'b1);
        chk("after_rst_data",  32'(dd_s), 32'd1);
        chk("after_rst_sat",   32'(dsat_s), 32'd0);
        chk("after_rst_count", 32'(dcnt_s), 32'd1);
        step();

        // Random traffic against the reference model
        for (int i = 0; i < 10000; i++) begin
            up_valid   = ($urandom % 4) != 0;
            up_data    = 4'($urandom);
            up_last    = ($urandom % 6) == 0;
            down_ready = ($urandom % 3) != 0;
            step();
        end
        up_valid = 1'b0; up_last = 1'b0; down_ready = 1'b1;
        repeat (4) step();
        chk("s_leftover", 32'(q_s.size()), 32'd0);
        chk("u_leftover", 32'(q_u.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
